// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the in-order integer pipeline.
// Tracks in-flight register writers (EX..WB), forwards operands to ID, stalls on load-use, flushes on taken branch.
module pipe_hazard_unit #(
    parameter int unsigned  XLEN       = 64,
    parameter int unsigned  REG_AW     = 5,
    parameter int unsigned  DEPTH      = 3,
    parameter int unsigned  LOAD_AVAIL = 2,
    localparam int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    id_valid,
    input  logic [REG_AW-1:0]       id_rs1,
    input  logic [REG_AW-1:0]       id_rs2,
    input  logic [REG_AW-1:0]       id_rd,
    input  logic                    id_wen,
    input  logic                    id_is_load,
    input  logic [XLEN-1:0]         rf_rs1,
    input  logic [XLEN-1:0]         rf_rs2,
    input  logic [DEPTH*XLEN-1:0]   slot_data,
    input  logic                    br_taken,
    output logic [XLEN-1:0]         rs1_val,
    output logic [XLEN-1:0]         rs2_val,
    output logic [SEL_W-1:0]        fwd_sel1,
    output logic [SEL_W-1:0]        fwd_sel2,
    output logic                    stall,
    output logic                    flush,
    output logic [31:0]             stall_cnt,
    output logic [31:0]             flush_cnt
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } sb_entry_t;

    sb_entry_t [DEPTH-1:0]       slot_q;
    sb_entry_t                   slot_in;
    logic [DEPTH-1:0][XLEN-1:0]  slot_val;
    logic                        avail1;
    logic                        avail2;
    logic [31:0]                 stall_cnt_q;
    logic [31:0]                 flush_cnt_q;

    assign slot_val  = slot_data;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    function automatic logic hit(input sb_entry_t e, input logic [REG_AW-1:0] src);
        return e.v && (e.rd == src) && (src != '0);
    endfunction

    // A load result only exists on slot_data once it has reached LOAD_AVAIL.
    function automatic logic ready(input sb_entry_t e, input int k);
        return !e.ld || (k >= int'(LOAD_AVAIL));
    endfunction

    // Oldest-to-youngest scan so the youngest matching writer is the one left standing.
    always_comb begin
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        avail1   = 1'b1;
        avail2   = 1'b1;
        rs1_val  = rf_rs1;
        rs2_val  = rf_rs2;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (hit(slot_q[IDX_W'(k)], id_rs1)) begin
                fwd_sel1 = SEL_W'(k + 1);
                avail1   = ready(slot_q[IDX_W'(k)], k);
                rs1_val  = slot_val[IDX_W'(k)];
            end
            if (hit(slot_q[IDX_W'(k)], id_rs2)) begin
                fwd_sel2 = SEL_W'(k + 1);
                avail2   = ready(slot_q[IDX_W'(k)], k);
                rs2_val  = slot_val[IDX_W'(k)];
            end
        end
    end

    // Flush wins over stall; a stalled or flushed ID instruction becomes a bubble in EX.
    always_comb begin
        flush   = br_taken;
        stall   = id_valid && !br_taken && !(avail1 && avail2);
        slot_in = '0;
        if (id_valid && id_wen && (id_rd != '0) && !stall && !br_taken) begin
            slot_in.v  = 1'b1;
            slot_in.rd = id_rd;
            slot_in.ld = id_is_load;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            slot_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            slot_q <= {slot_q[DEPTH-2:0], slot_in};
            if (stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: instance a (DEPTH=3, LOAD_AVAIL=2), instance b (DEPTH=4, LOAD_AVAIL=3).
module tb_pipe_hazard_unit;

    localparam logic [63:0] RF1 = 64'h1111;
    localparam logic [63:0] RF2 = 64'h2222;
    localparam logic [63:0] X64 = 64'h0;
    localparam logic [31:0] FE  = 32'hFFFF_FFFE;
    localparam logic [31:0] FF  = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [15:0] id;
        logic        b;
        logic        st;
        logic        fl;
        logic        c1;
        logic [3:0]  s1;
        logic [63:0] v1;
        logic        c2;
        logic [3:0]  s2;
        logic [63:0] v2;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_wen;
    logic        id_is_load;
    logic        br_taken;
    logic [63:0] sd [4];
    logic [191:0] slot_data_a;
    logic [255:0] slot_data_b;

    logic [63:0] a_v1, a_v2, b_v1, b_v2;
    logic [1:0]  a_s1, a_s2;
    logic [2:0]  b_s1, b_s2;
    logic        a_st, a_fl, b_st, b_fl;
    logic [31:0] a_sc, a_fc, b_sc, b_fc;

    exp_t q [$];
    exp_t me;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    assign slot_data_a = {sd[2], sd[1], sd[0]};
    assign slot_data_b = {sd[3], sd[2], sd[1], sd[0]};

    pipe_hazard_unit #(.XLEN(64), .REG_AW(5), .DEPTH(3), .LOAD_AVAIL(2)) dut_a (
        .sys_clk(clk), .sys_rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .rf_rs1(RF1), .rf_rs2(RF2),
        .slot_data(slot_data_a), .br_taken(br_taken), .rs1_val(a_v1), .rs2_val(a_v2),
        .fwd_sel1(a_s1), .fwd_sel2(a_s2), .stall(a_st), .flush(a_fl),
        .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    pipe_hazard_unit #(.XLEN(64), .REG_AW(5), .DEPTH(4), .LOAD_AVAIL(3)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .rf_rs1(RF1), .rf_rs2(RF2),
        .slot_data(slot_data_b), .br_taken(br_taken), .rs1_val(b_v1), .rs2_val(b_v2),
        .fwd_sel1(b_s1), .fwd_sel2(b_s2), .stall(b_st), .flush(b_fl),
        .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h expected %h", nm, id, act, exp);
    endtask

    task automatic set_in(input int v, input int rs1, input int rs2, input int rd,
                          input int wen, input int ld, input int br);
        id_valid   = 1'(v);
        id_rs1     = 5'(rs1);
        id_rs2     = 5'(rs2);
        id_rd      = 5'(rd);
        id_wen     = 1'(wen);
        id_is_load = 1'(ld);
        br_taken   = 1'(br);
    endtask

    function automatic exp_t mk(input int b, input int st, input int fl,
                                input int c1, input int s1, input logic [63:0] v1,
                                input int c2, input int s2, input logic [63:0] v2,
                                input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        e.id = 16'(cyc);
        e.b  = 1'(b);
        e.st = 1'(st);
        e.fl = 1'(fl);
        e.c1 = 1'(c1);
        e.s1 = 4'(s1);
        e.v1 = v1;
        e.c2 = 1'(c2);
        e.s2 = 4'(s2);
        e.v2 = v2;
        e.sc = sc;
        e.fc = fc;
        return e;
    endfunction

    // One ID cycle: queue the expectation, then move to just after the next edge.
    task automatic step(input exp_t e);
        q.push_back(e);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are settled mid-cycle; compare against the oldest expectation.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            me = q.pop_front();
            if (me.b) begin
                chk("b_stall", int'(me.id), 64'(b_st), 64'(me.st));
                chk("b_flush", int'(me.id), 64'(b_fl), 64'(me.fl));
                chk("b_stall_cnt", int'(me.id), 64'(b_sc), 64'(me.sc));
                chk("b_flush_cnt", int'(me.id), 64'(b_fc), 64'(me.fc));
                if (me.c1) begin
                    chk("b_fwd_sel1", int'(me.id), 64'(b_s1), 64'(me.s1));
                    chk("b_rs1_val", int'(me.id), b_v1, me.v1);
                end
                if (me.c2) begin
                    chk("b_fwd_sel2", int'(me.id), 64'(b_s2), 64'(me.s2));
                    chk("b_rs2_val", int'(me.id), b_v2, me.v2);
                end
            end else begin
                chk("a_stall", int'(me.id), 64'(a_st), 64'(me.st));
                chk("a_flush", int'(me.id), 64'(a_fl), 64'(me.fl));
                chk("a_stall_cnt", int'(me.id), 64'(a_sc), 64'(me.sc));
                chk("a_flush_cnt", int'(me.id), 64'(a_fc), 64'(me.fc));
                if (me.c1) begin
                    chk("a_fwd_sel1", int'(me.id), 64'(a_s1), 64'(me.s1));
                    chk("a_rs1_val", int'(me.id), a_v1, me.v1);
                end
                if (me.c2) begin
                    chk("a_fwd_sel2", int'(me.id), 64'(a_s2), 64'(me.s2));
                    chk("a_rs2_val", int'(me.id), a_v2, me.v2);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        sd[0] = 64'h1234; sd[1] = 64'h5555; sd[2] = 64'h7777; sd[3] = 64'h9999;
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // idle after reset, then ALU chain on x5 through EX, MEM, WB and retirement
        set_in(0, 0, 0, 0, 0, 0, 0);  step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, 0, 0));
        set_in(1, 0, 0, 5, 1, 0, 0);  step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, 0, 0));
        set_in(1, 5, 6, 8, 0, 0, 0);  step(mk(0, 0, 0, 1, 1, 64'h1234, 1, 0, RF2, 0, 0));
        set_in(1, 5, 5, 0, 0, 0, 0);  step(mk(0, 0, 0, 1, 2, 64'h5555, 1, 2, 64'h5555, 0, 0));
        set_in(1, 5, 0, 0, 0, 0, 0);  step(mk(0, 0, 0, 1, 3, 64'h7777, 1, 0, RF2, 0, 0));
        step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, 0, 0));

        // load-use on x7: two stall cycles, then forwarded from WB
        set_in(1, 0, 0, 7, 1, 1, 0);  step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, 0, 0));
        set_in(1, 0, 7, 9, 1, 0, 0);  step(mk(0, 1, 0, 0, 0, X64, 0, 0, X64, 0, 0));
        step(mk(0, 1, 0, 0, 0, X64, 0, 0, X64, 1, 0));
        step(mk(0, 0, 0, 1, 0, RF1, 1, 3, 64'h7777, 2, 0));

        // youngest x3 wins; rd=0 writer never tracked
        set_in(1, 0, 0, 3, 1, 0, 0);  step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, 2, 0));
        set_in(1, 0, 0, 0, 1, 0, 0);  step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, 2, 0));
        set_in(1, 0, 0, 3, 1, 0, 0);  step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, 2, 0));
        sd[0] = 64'hAA; sd[2] = 64'hBB;
        set_in(1, 3, 0, 0, 0, 0, 0);  step(mk(0, 0, 0, 1, 1, 64'hAA, 1, 0, RF2, 2, 0));
        step(mk(0, 0, 0, 1, 2, 64'h5555, 1, 0, RF2, 2, 0));

        // taken branch over a pending load-use: flush, no stall, ID instr dropped
        set_in(1, 0, 0, 4, 1, 1, 0);  step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, 2, 0));
        set_in(1, 4, 0, 10, 1, 0, 1); step(mk(0, 0, 1, 0, 0, X64, 1, 0, RF2, 2, 0));
        set_in(0, 4, 10, 0, 0, 0, 0); step(mk(0, 0, 0, 0, 0, X64, 1, 0, RF2, 2, 1));

        // stall counter saturation from a preloaded value
        force dut_a.stall_cnt_q = FE;
        #1;
        release dut_a.stall_cnt_q;
        set_in(1, 0, 0, 11, 1, 1, 0);  step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, FE, 1));
        set_in(1, 11, 0, 0, 0, 0, 0);  step(mk(0, 1, 0, 0, 0, X64, 0, 0, X64, FE, 1));
        step(mk(0, 1, 0, 0, 0, X64, 0, 0, X64, FF, 1));
        set_in(1, 11, 0, 12, 1, 1, 0); step(mk(0, 0, 0, 1, 3, 64'hBB, 1, 0, RF2, FF, 1));
        set_in(1, 12, 0, 0, 0, 0, 0);  step(mk(0, 1, 0, 0, 0, X64, 0, 0, X64, FF, 1));
        step(mk(0, 1, 0, 0, 0, X64, 0, 0, X64, FF, 1));
        step(mk(0, 0, 0, 1, 3, 64'hBB, 1, 0, RF2, FF, 1));

        // reset with three loads in flight
        set_in(1, 0, 0, 1, 1, 1, 0);  step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, FF, 1));
        set_in(1, 0, 0, 2, 1, 1, 0);  step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, FF, 1));
        set_in(1, 0, 0, 13, 1, 1, 0); step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, FF, 1));
        rst = 1'b1;
        set_in(1, 13, 2, 0, 0, 0, 0); step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, 0, 0));
        rst = 1'b0;
        step(mk(0, 0, 0, 1, 0, RF1, 1, 0, RF2, 0, 0));

        // DEPTH=4, LOAD_AVAIL=3: three stall cycles, forward from slot 3
        set_in(1, 0, 0, 7, 1, 1, 0);  step(mk(1, 0, 0, 1, 0, RF1, 1, 0, RF2, 0, 0));
        set_in(1, 0, 7, 0, 0, 0, 0);  step(mk(1, 1, 0, 0, 0, X64, 0, 0, X64, 0, 0));
        step(mk(1, 1, 0, 0, 0, X64, 0, 0, X64, 1, 0));
        step(mk(1, 1, 0, 0, 0, X64, 0, 0, X64, 2, 0));
        step(mk(1, 0, 0, 1, 0, RF1, 1, 4, 64'h9999, 3, 0));
        set_in(1, 0, 0, 8, 1, 0, 0);  step(mk(1, 0, 0, 1, 0, RF1, 1, 0, RF2, 3, 0));
        set_in(1, 8, 0, 0, 0, 0, 0);  step(mk(1, 0, 0, 1, 1, 64'hAA, 1, 0, RF2, 3, 0));
        set_in(1, 0, 0, 0, 0, 0, 1);  step(mk(1, 0, 1, 1, 0, RF1, 1, 0, RF2, 3, 0));
        set_in(0, 0, 0, 0, 0, 0, 0);  step(mk(1, 0, 0, 1, 0, RF1, 1, 0, RF2, 3, 1));

        repeat (3) @(negedge clk);
        #1;
        chk("queue_drained", cyc, 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
